// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 types, field widths and the operand transmitter state encoding.
package dlfloat_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 9;

  typedef logic [15:0] dlfloat16_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2,
    WAIT   = 2'd3
  } tx_state_t;

  // True when the exponent field (bits [14:9]) is all zeros.
  function automatic logic exp_is_zero(dlfloat16_t v);
    return v[MANT_W +: EXP_W] == '0;
  endfunction

endpackage

// File: rtl/dlfloat_operand_tx_if.sv
// Operand/result bus between a DLFloat16 source, the transmitter and the MAC pins.
interface dlfloat_operand_tx_if;
  import dlfloat_pkg::*;

  logic       in_valid;
  logic       in_ready;
  dlfloat16_t in_a;
  dlfloat16_t in_b;
  dlfloat16_t data_out;
  logic       data_valid;
  logic       data_phase;
  dlfloat16_t res_in;
  dlfloat16_t res_out;
  logic       res_valid;
  logic       res_zero;
  logic       busy;

  modport master (
    output in_valid, in_a, in_b, res_in,
    input  in_ready, data_out, data_valid, data_phase, res_out, res_valid, res_zero, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, res_in,
    output in_ready, data_out, data_valid, data_phase, res_out, res_valid, res_zero, busy
  );

endinterface

// File: rtl/dlfloat_lat_counter.sv
// Loadable 4-bit down counter that flags when it holds exactly one.
module dlfloat_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       is_one
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one = (count_q == 4'd1);

endmodule

// File: rtl/dlfloat_operand_tx.sv
// Serializes a DLFloat16 operand pair (A then B) onto the MAC pin bus and optionally
// captures the returned result after RESULT_LATENCY cycles (DLFLOAT_TX_RESULT_CAPTURE_EN).
module dlfloat_operand_tx
  import dlfloat_pkg::*;
#(
  parameter int RESULT_LATENCY = 4
) (
  input logic                 clk,
  input logic                 rst,
  dlfloat_operand_tx_if.slave bus
);

  tx_state_t  state_q, state_d;
  dlfloat16_t a_q, a_d;
  dlfloat16_t b_q, b_d;
  logic       in_ready;
  logic       accept;
  dlfloat16_t data_out;
  logic       data_valid;
  logic       data_phase;

`ifdef DLFLOAT_TX_RESULT_CAPTURE_EN
  logic       cnt_is_one;
  logic       capture;
  dlfloat16_t res_out_q, res_out_d;
  logic       res_valid_q, res_valid_d;
  logic       res_zero_q, res_zero_d;

  dlfloat_lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == SEND_B),
    .load_val (4'(RESULT_LATENCY)),
    .dec      (state_q == WAIT),
    .is_one   (cnt_is_one)
  );

  // A result is pending from SEND_A through WAIT, so only IDLE may accept.
  assign in_ready = (state_q == IDLE);
`else
  localparam int unused_latency = RESULT_LATENCY;
  logic unused_res_in;
  assign unused_res_in = ^bus.res_in;

  // Accepting during SEND_B lets pairs stream back-to-back, one word per cycle.
  assign in_ready = (state_q == IDLE) || (state_q == SEND_B);
`endif

  assign accept = in_ready & bus.in_valid;

  // NOTE: every output of this block gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    data_out   = '0;
    data_valid = 1'b0;
    data_phase = 1'b0;
`ifdef DLFLOAT_TX_RESULT_CAPTURE_EN
    capture    = 1'b0;
`endif
    if (accept) begin
      a_d = bus.in_a;
      b_d = bus.in_b;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SEND_A;
      end
      SEND_A: begin
        data_out   = a_q;
        data_valid = 1'b1;
        state_d    = SEND_B;
      end
      SEND_B: begin
        data_out   = b_q;
        data_valid = 1'b1;
        data_phase = 1'b1;
`ifdef DLFLOAT_TX_RESULT_CAPTURE_EN
        state_d    = WAIT;
`else
        state_d    = accept ? SEND_A : IDLE;
`endif
      end
`ifdef DLFLOAT_TX_RESULT_CAPTURE_EN
      WAIT: begin
        if (cnt_is_one) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

`ifdef DLFLOAT_TX_RESULT_CAPTURE_EN
  always_comb begin
    res_out_d   = res_out_q;
    res_zero_d  = res_zero_q;
    res_valid_d = capture;
    if (capture) begin
      res_out_d  = bus.res_in;
      res_zero_d = exp_is_zero(bus.res_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      res_out_q   <= res_out_d;
      res_valid_q <= res_valid_d;
      res_zero_q  <= res_zero_d;
    end
  end

  assign bus.res_out   = res_out_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_zero  = res_zero_q;
`else
  assign bus.res_out   = '0;
  assign bus.res_valid = 1'b0;
  assign bus.res_zero  = 1'b0;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.data_phase = data_phase;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dlfloat_operand_tx.sv
// Directed, table-driven bench for dlfloat_operand_tx; adapts to DLFLOAT_TX_RESULT_CAPTURE_EN.
module tb_dlfloat_operand_tx;
  import dlfloat_pkg::*;

  logic clk;
  logic rst;

  dlfloat_operand_tx_if bus ();
  dlfloat_operand_tx_if bus_l1 ();
  dlfloat_operand_tx_if bus_l15 ();

  dlfloat_operand_tx #(.RESULT_LATENCY(4))  u_dut     (.clk(clk), .rst(rst), .bus(bus));
  dlfloat_operand_tx #(.RESULT_LATENCY(1))  u_dut_l1  (.clk(clk), .rst(rst), .bus(bus_l1));
  dlfloat_operand_tx #(.RESULT_LATENCY(15)) u_dut_l15 (.clk(clk), .rst(rst), .bus(bus_l15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    dlfloat16_t a;
    dlfloat16_t b;
    dlfloat16_t rin;
    logic       e_rdy;
    logic       e_busy;
    logic       e_dv;
    dlfloat16_t e_d;
    logic       e_ph;
    logic       e_rv;
    dlfloat16_t e_res;
    logic       e_rz;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(logic iv, dlfloat16_t a, dlfloat16_t b, dlfloat16_t rin,
                              logic e_rdy, logic e_busy, logic e_dv, dlfloat16_t e_d,
                              logic e_ph, logic e_rv, dlfloat16_t e_res, logic e_rz);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.rin = rin;
    v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_dv = e_dv; v.e_d = e_d;
    v.e_ph = e_ph; v.e_rv = e_rv; v.e_res = e_res; v.e_rz = e_rz;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int rv_cnt;
  int dv_cnt;
  int lat1;
  int lat15;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;     bus.in_a = '0;     bus.in_b = '0;     bus.res_in = '0;
    bus_l1.in_valid = 1'b0;  bus_l1.in_a = '0;  bus_l1.in_b = '0;  bus_l1.res_in = '0;
    bus_l15.in_valid = 1'b0; bus_l15.in_a = '0; bus_l15.in_b = '0; bus_l15.res_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef DLFLOAT_TX_RESULT_CAPTURE_EN
    // Single transfer, L = 4: words in cycles 1/2, result pulse in cycle 7.
    //                 iv    a         b         rin       rdy   busy  dv    data      ph    rv    res       rz
    tbl.push_back(mk(1'b1, 16'h3E00, 16'h4000, 16'h4100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h4100, 1'b0, 1'b1, 1'b1, 16'h3E00, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h4100, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b1, 1'b0, 16'h0000, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h4100, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h4100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4100, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h4100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4100, 1'b0));
    // in_valid held through busy with changing in_a; re-accept in the result cycle.
    tbl.push_back(mk(1'b1, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4100, 1'b0));
    tbl.push_back(mk(1'b1, 16'hAAAA, 16'hBBBB, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h4100, 1'b0));
    tbl.push_back(mk(1'b1, 16'hCCCC, 16'hDDDD, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h4100, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b1, 16'h5555, 16'h6666, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4100, 1'b0));
    tbl.push_back(mk(1'b1, 16'h5555, 16'h6666, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h8200, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h8200, 1'b0, 1'b1, 1'b1, 16'h6666, 1'b1, 1'b0, 16'h0000, 1'b1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h8200, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h8200, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h8200, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'h8200, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h8200, 1'b0));
`else
    // Three pairs streamed back-to-back; zero operands pass through unchanged.
    tbl.push_back(mk(1'b1, 16'h3E00, 16'h4000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b1, 16'h0000, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h3E00, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b1, 16'h0000, 16'h8000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h4000, 1'b1, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b1, 16'hFFFF, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b1, 16'hFFFF, 16'h1234, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      bus.in_valid = tbl[i].iv;
      bus.in_a     = tbl[i].a;
      bus.in_b     = tbl[i].b;
      bus.res_in   = tbl[i].rin;
      @(negedge clk);
      check($sformatf("row%0d in_ready", i),   16'(bus.in_ready),   16'(tbl[i].e_rdy));
      check($sformatf("row%0d busy", i),       16'(bus.busy),       16'(tbl[i].e_busy));
      check($sformatf("row%0d data_valid", i), 16'(bus.data_valid), 16'(tbl[i].e_dv));
      check($sformatf("row%0d data_out", i),   bus.data_out,        tbl[i].e_d);
      check($sformatf("row%0d data_phase", i), 16'(bus.data_phase), 16'(tbl[i].e_ph));
      check($sformatf("row%0d res_valid", i),  16'(bus.res_valid),  16'(tbl[i].e_rv));
      check($sformatf("row%0d res_out", i),    bus.res_out,         tbl[i].e_res);
      check($sformatf("row%0d res_zero", i),   16'(bus.res_zero),   16'(tbl[i].e_rz));
      next_cycle();
    end

    // Reset while the B word is on the bus: transfer aborts, no result follows.
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h7E00;
    bus.in_b     = 16'h01FF;
    bus.res_in   = 16'h1234;
    next_cycle();
    bus.in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("abort pre data_out", bus.data_out, 16'h01FF);
    check("abort pre data_phase", 16'(bus.data_phase), 16'h0001);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("abort data_valid", 16'(bus.data_valid), 16'h0000);
    check("abort data_out", bus.data_out, 16'h0000);
    check("abort in_ready", 16'(bus.in_ready), 16'h0001);
    check("abort busy", 16'(bus.busy), 16'h0000);
    check("abort res_out", bus.res_out, 16'h0000);
    rv_cnt = 0;
    dv_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.res_valid)  rv_cnt++;
      if (bus.data_valid) dv_cnt++;
      next_cycle();
    end
    check("abort res_valid pulses", 16'(rv_cnt), 16'h0000);
    check("abort words after reset", 16'(dv_cnt), 16'h0000);

`ifdef DLFLOAT_TX_RESULT_CAPTURE_EN
    // Latency extremes: L = 1 -> cycle 4, L = 15 -> cycle 18 (accept = cycle 0).
    bus_l1.in_valid  = 1'b1; bus_l1.in_a  = 16'h3E00; bus_l1.in_b  = 16'h4000; bus_l1.res_in  = 16'h4100;
    bus_l15.in_valid = 1'b1; bus_l15.in_a = 16'h3E00; bus_l15.in_b = 16'h4000; bus_l15.res_in = 16'h0200;
    @(negedge clk);
    check("lat in_ready l1", 16'(bus_l1.in_ready), 16'h0001);
    check("lat in_ready l15", 16'(bus_l15.in_ready), 16'h0001);
    next_cycle();
    bus_l1.in_valid  = 1'b0;
    bus_l15.in_valid = 1'b0;
    lat1  = -1;
    lat15 = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (bus_l1.res_valid  && lat1  < 0) lat1  = cyc;
      if (bus_l15.res_valid && lat15 < 0) lat15 = cyc;
      next_cycle();
    end
    check("latency L=1 cycle", 16'(lat1), 16'd4);
    check("latency L=15 cycle", 16'(lat15), 16'd18);
    check("latency L=1 res_out", bus_l1.res_out, 16'h4100);
    check("latency L=15 res_out", bus_l15.res_out, 16'h0200);
    check("latency L=15 res_zero", 16'(bus_l15.res_zero), 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
